// File: rtl/imm_ext.sv
// -----------------------------------------------------------------------------
// imm_ext
//
// Immediate extension unit for the P4 single-cycle MIPS datapath. Widens the
// raw 16-bit instruction immediate to the full data width in two ways:
//
//   * Always-valid combinational outputs for the sign-extended and the
//     zero-extended immediate. These follow imm with no clock or reset
//     dependence.
//   * A one-cycle registered result, selected by ext_op, carrying a valid
//     flag. It feeds the ALU-B mux and the branch adder.
//
// Parameters
//   IMM_W   immediate input width (16)
//   DATA_W  extended output width (32); must be at least IMM_W+2 so the
//           branch offset keeps its sign after the <<2
//
// Ports
//   clk         in   1       system clock, rising edge
//   reset       in   1       asynchronous, active-high reset
//   imm         in   IMM_W   raw instruction immediate (instr[15:0])
//   ext_op      in   2       00 zero-ext, 01 sign-ext, 10 LUI, 11 branch offset
//   in_valid    in   1       capture imm/ext_op on this rising edge
//   immSignExt  out  DATA_W  combinational sign-extended immediate
//   immZeroExt  out  DATA_W  combinational zero-extended immediate
//   ext_out     out  DATA_W  registered op-selected result
//   out_valid   out  1       ext_out holds a result captured on the last edge
// -----------------------------------------------------------------------------
module imm_ext #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        ext_op,
    input  logic              in_valid,
    output logic [DATA_W-1:0] immSignExt,
    output logic [DATA_W-1:0] immZeroExt,
    output logic [DATA_W-1:0] ext_out,
    output logic              out_valid
);

    // Encoding of the ext_op selector.
    typedef enum logic [1:0] {
        EXT_ZERO   = 2'b00,
        EXT_SIGN   = 2'b01,
        EXT_LUI    = 2'b10,
        EXT_BRANCH = 2'b11
    } extOpE;

    localparam int PAD_W = DATA_W - IMM_W;

    logic [DATA_W-1:0] luiValue;
    logic [DATA_W-1:0] branchValue;
    logic [DATA_W-1:0] decoded;

    logic [DATA_W-1:0] ext_d;
    logic [DATA_W-1:0] ext_q;
    logic              valid_d;
    logic              valid_q;

    // The two plain extensions are pure wiring; X on imm propagates straight
    // through, so a bad immediate is visible in simulation immediately.
    assign immSignExt = {{PAD_W{imm[IMM_W-1]}}, imm};
    assign immZeroExt = {{PAD_W{1'b0}}, imm};

    // LUI places the immediate in the upper half with zeros below. Shifting
    // the zero-extended value keeps this correct for any DATA_W >= IMM_W.
    assign luiValue = immZeroExt << PAD_W;

    // Branch offsets are word offsets: sign-extend first, then scale by 4.
    // The two bits shifted out of the top are copies of the sign, so the
    // result keeps the sign of the immediate.
    assign branchValue = immSignExt << 2;

    // Select the registered result from the decoded op.
    always_comb begin
        decoded = immZeroExt;
        unique case (extOpE'(ext_op))
            EXT_ZERO:   decoded = immZeroExt;
            EXT_SIGN:   decoded = immSignExt;
            EXT_LUI:    decoded = luiValue;
            EXT_BRANCH: decoded = branchValue;
            default:    decoded = immZeroExt;
        endcase
    end

    // Next-state logic: a valid input captures a new result; otherwise the
    // previous result is held but no longer flagged as fresh.
    always_comb begin
        ext_d   = ext_q;
        valid_d = 1'b0;
        if (in_valid) begin
            ext_d   = decoded;
            valid_d = 1'b1;
        end
    end

    // Result register. Reset clears both the data and the valid flag at once,
    // which also throws away anything captured just before reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            ext_q   <= ext_d;
            valid_q <= valid_d;
        end
    end

    assign ext_out   = ext_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_imm_ext.sv
// -----------------------------------------------------------------------------
// tb_imm_ext
//
// Self-checking bench for imm_ext. The combinational extensions are checked
// right after each input change. Every stimulus pushes its expected registered
// result onto a scoreboard queue, and the entry is popped and compared one
// edge later. A vector table covers the fixed cases, hand-written sequences
// cover hold and reset corners, and a random run follows the table.
// -----------------------------------------------------------------------------
module tb_imm_ext;

    logic        clk;
    logic        reset;
    logic [15:0] imm;
    logic [1:0]  ext_op;
    logic        in_valid;
    logic [31:0] immSignExt;
    logic [31:0] immZeroExt;
    logic [31:0] ext_out;
    logic        out_valid;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] ext;
        logic        valid;
    } expT;

    expT         scoreboard[$];
    logic [31:0] modelExt;

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  op;
        logic [31:0] expSign;
        logic [31:0] expZero;
        logic [31:0] expExt;
    } vecT;

    vecT vectors[$];

    imm_ext #(.IMM_W(16), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .imm        (imm),
        .ext_op     (ext_op),
        .in_valid   (in_valid),
        .immSignExt (immSignExt),
        .immZeroExt (immZeroExt),
        .ext_out    (ext_out),
        .out_valid  (out_valid)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends, even if something stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check32(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Independent reference for the op-selected result.
    function automatic logic [31:0] refDecode(input logic [15:0] i,
                                              input logic [1:0] op);
        logic [31:0] s;
        s = {{16{i[15]}}, i};
        case (op)
            2'b00:   return {16'h0000, i};
            2'b01:   return s;
            2'b10:   return {i, 16'h0000};
            default: return {s[29:0], 2'b00};
        endcase
    endfunction

    // Drive one cycle of inputs (away from the edge), check the combinational
    // outputs, and queue the registered result expected after the next edge.
    task automatic applyStimulus(input logic [15:0] i, input logic [1:0] op,
                                 input logic v, input logic [31:0] expSign,
                                 input logic [31:0] expZero,
                                 input logic [31:0] expExt);
        expT e;
        imm      = i;
        ext_op   = op;
        in_valid = v;
        #1;
        check32("immSignExt", immSignExt, expSign);
        check32("immZeroExt", immZeroExt, expZero);
        if (v) modelExt = expExt;
        e.ext   = modelExt;
        e.valid = v;
        scoreboard.push_back(e);
    endtask

    // Advance past the next rising edge and compare against the scoreboard.
    task automatic checkOutput(input string tag);
        expT e;
        @(posedge clk);
        #1;
        if (scoreboard.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_scoreboard actual=empty required=entry", tag);
        end else begin
            e = scoreboard.pop_front();
            check1({tag, "_valid"}, out_valid, e.valid);
            check32({tag, "_ext"}, ext_out, e.ext);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        modelExt = 32'h0;
        reset    = 1'b1;
        imm      = 16'h0000;
        ext_op   = 2'b00;
        in_valid = 1'b0;

        // Fixed vectors: op sequence on f13a, then sign/width boundaries.
        vectors.push_back('{16'hf13a, 2'b00, 32'hfffff13a, 32'h0000f13a, 32'h0000f13a});
        vectors.push_back('{16'hf13a, 2'b01, 32'hfffff13a, 32'h0000f13a, 32'hfffff13a});
        vectors.push_back('{16'hf13a, 2'b10, 32'hfffff13a, 32'h0000f13a, 32'hf13a0000});
        vectors.push_back('{16'hf13a, 2'b11, 32'hfffff13a, 32'h0000f13a, 32'hffffc4e8});
        vectors.push_back('{16'h7fff, 2'b01, 32'h00007fff, 32'h00007fff, 32'h00007fff});
        vectors.push_back('{16'h8000, 2'b01, 32'hffff8000, 32'h00008000, 32'hffff8000});
        vectors.push_back('{16'h8000, 2'b11, 32'hffff8000, 32'h00008000, 32'hfffe0000});
        vectors.push_back('{16'h7fff, 2'b11, 32'h00007fff, 32'h00007fff, 32'h0001fffc});
        vectors.push_back('{16'hffff, 2'b11, 32'hffffffff, 32'h0000ffff, 32'hfffffffc});
        vectors.push_back('{16'h8000, 2'b10, 32'hffff8000, 32'h00008000, 32'h80000000});
        vectors.push_back('{16'h0001, 2'b10, 32'h00000001, 32'h00000001, 32'h00010000});
        vectors.push_back('{16'hffff, 2'b00, 32'hffffffff, 32'h0000ffff, 32'h0000ffff});

        // Reset state, checked while reset is held.
        #2;
        check32("reset_ext", ext_out, 32'h0);
        check1("reset_valid", out_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check1("post_release_valid", out_valid, 1'b0);

        // Back-to-back table vectors, one per edge.
        for (int k = 0; k < vectors.size(); k++) begin
            applyStimulus(vectors[k].imm, vectors[k].op, 1'b1,
                          vectors[k].expSign, vectors[k].expZero,
                          vectors[k].expExt);
            checkOutput($sformatf("vec%0d", k));
        end

        // Put ffffc4e8 back in the register, then idle: the value holds while
        // the valid flag drops.
        applyStimulus(16'hf13a, 2'b11, 1'b1, 32'hfffff13a, 32'h0000f13a, 32'hffffc4e8);
        checkOutput("branch_f13a");
        applyStimulus(16'h1234, 2'b10, 1'b0, 32'h00001234, 32'h00001234, 32'h0);
        checkOutput("hold1");
        applyStimulus(16'h0000, 2'b01, 1'b0, 32'h00000000, 32'h00000000, 32'h0);
        checkOutput("hold2");

        // Async reset between edges while a result is valid.
        applyStimulus(16'h00ab, 2'b00, 1'b1, 32'h000000ab, 32'h000000ab, 32'h000000ab);
        checkOutput("pre_reset");
        #2;
        reset = 1'b1;
        #1;
        check32("async_reset_ext", ext_out, 32'h0);
        check1("async_reset_valid", out_valid, 1'b0);
        scoreboard.delete();
        modelExt = 32'h0;
        // A valid input during reset must never surface.
        in_valid = 1'b1;
        imm      = 16'h5555;
        @(posedge clk);
        #1;
        check32("reset_held_ext", ext_out, 32'h0);
        check1("reset_held_valid", out_valid, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(16'h5555, 2'b01, 1'b0, 32'h00005555, 32'h00005555, 32'h0);
            checkOutput($sformatf("after_release%0d", k));
        end

        // Random run against the reference model.
        for (int k = 0; k < 1000; k++) begin
            logic [15:0] ri;
            logic [1:0]  ro;
            logic        rv;
            ri = 16'($urandom);
            ro = 2'($urandom_range(0, 3));
            rv = ($urandom_range(0, 3) != 0);
            applyStimulus(ri, ro, rv, {{16{ri[15]}}, ri}, {16'h0, ri},
                          refDecode(ri, ro));
            checkOutput("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
